simple_cpu_core_p: RTL and testbench

- Parametrised successor to the fixed 8-bit, 4-register fetch/execute pair.
- Holds an internal loadable instruction memory, a multi-cycle FETCH/EXEC state machine, a generic register file, branch/jump, halt, hold and signed-overflow flag.
- Sits under the top level; the top drives program load and start and observes the registers.

---
 rtl/simple_cpu_core_p.sv | 143 ++++++++++++++
 tb/tb_simple_cpu_core_p.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_cpu_core_p.sv
// Parametrised multi-cycle FETCH/EXEC core with loadable instruction memory,
// generic register file, branch/jump, halt, hold and sticky signed overflow.
module simple_cpu_core_p #(
  parameter  int DATA_W     = 8,
  parameter  int NUM_REGS   = 4,
  parameter  int IMEM_DEPTH = 64,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic                       prog_we,
  input  logic [AW-1:0]              prog_addr,
  input  logic [19:0]                prog_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       halted,
  output logic [AW-1:0]              pc,
  output logic                       ovf,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  localparam int         RIW   = $clog2(NUM_REGS);
  localparam int         MSB   = DATA_W - 1;
  localparam logic [4:0] NREGS = 5'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND  = 4'h3,
    OP_OR   = 4'h4, OP_ADDI = 4'h5, OP_LI = 4'h6, OP_BEQZ = 4'h7,
    OP_JMP  = 4'h8, OP_HALT = 4'hF
  } op_e;

  state_e              state_q, state_d;
  logic [19:0]         ir;
  logic [19:0]         imem [IMEM_DEPTH];
  logic [DATA_W-1:0]   regs [NUM_REGS];

  op_e                 op;
  logic [3:0]          rd, rs, rt;
  logic [7:0]          imm;
  logic                rd_ok, rs_ok, rt_ok;
  logic [DATA_W-1:0]   rs_val, rt_val, alu_b, sext_imm, res;
  logic                wr_en, ovf_set;
  logic [AW-1:0]       pc_d;

  assign op  = op_e'(ir[19:16]);
  assign rd  = ir[15:12];
  assign rs  = ir[11:8];
  assign imm = ir[7:0];
  assign rt  = imm[3:0];

  // Indices past the last architectural register read as zero and never write.
  assign rd_ok  = {1'b0, rd} < NREGS;
  assign rs_ok  = {1'b0, rs} < NREGS;
  assign rt_ok  = {1'b0, rt} < NREGS;
  assign rs_val = rs_ok ? regs[rs[RIW-1:0]] : '0;
  assign rt_val = rt_ok ? regs[rt[RIW-1:0]] : '0;

  assign busy   = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign halted = (state_q == S_HALT);

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int i = 0; i < DATA_W; i++) sext_imm[i] = (i < 8) ? imm[3'(i)] : imm[7];
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_FETCH;
      S_FETCH:        if (!hold) state_d = S_EXEC;
      S_EXEC:         if (!hold) state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_b   = rt_val;
    res     = '0;
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    pc_d    = pc + AW'(1);
    case (op)
      OP_ADD, OP_ADDI: begin
        if (op == OP_ADDI) alu_b = sext_imm;
        res     = rs_val + alu_b;
        wr_en   = 1'b1;
        ovf_set = (rs_val[MSB] == alu_b[MSB]) && (res[MSB] != rs_val[MSB]);
      end
      OP_SUB: begin
        res     = rs_val - rt_val;
        wr_en   = 1'b1;
        ovf_set = (rs_val[MSB] != rt_val[MSB]) && (res[MSB] != rs_val[MSB]);
      end
      OP_AND:  begin res = rs_val & rt_val; wr_en = 1'b1; end
      OP_OR:   begin res = rs_val | rt_val; wr_en = 1'b1; end
      OP_LI:   begin res = sext_imm;        wr_en = 1'b1; end
      OP_BEQZ: if (rs_val == '0) pc_d = imm[AW-1:0];
      OP_JMP:  pc_d = imm[AW-1:0];
      OP_HALT: pc_d = pc;
      default: ;
    endcase
  end

  // NOTE: program memory has no reset; a core reset must leave the loaded program intact.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE || state_q == S_HALT)) imem[prog_addr] <= prog_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc      <= '0;
      ovf     <= 1'b0;
      ir      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE, S_HALT: if (start) begin
          pc  <= '0;
          ovf <= 1'b0;
        end
        S_FETCH: if (!hold) ir <= imem[pc];
        S_EXEC: if (!hold) begin
          pc <= pc_d;
          if (ovf_set) ovf <= 1'b1;
          if (wr_en && rd_ok) regs[rd[RIW-1:0]] <= res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cpu_core_p.sv
// Self-checking bench for simple_cpu_core_p: table of programs scored through a
// queue, plus hand sequences for hold, busy protection, reset and wide parameters.
module tb_simple_cpu_core_p;

  logic        clk = 1'b0;
  logic        reset, hold, prog_we, start;
  logic [5:0]  prog_addr;
  logic [19:0] prog_data;
  logic        busy, halted, ovf;
  logic [5:0]  pc;
  logic [31:0] regs_flat;

  logic         prog_we16, start16;
  logic [5:0]   prog_addr16;
  logic [19:0]  prog_data16;
  logic         busy16, halted16, ovf16;
  logic [5:0]   pc16;
  logic [127:0] regs_flat16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  simple_cpu_core_p dut (
    .clk(clk), .reset(reset), .hold(hold), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .halted(halted), .pc(pc),
    .ovf(ovf), .regs_flat(regs_flat)
  );

  simple_cpu_core_p #(.DATA_W(16), .NUM_REGS(8), .IMEM_DEPTH(64)) dut16 (
    .clk(clk), .reset(reset), .hold(hold), .prog_we(prog_we16), .prog_addr(prog_addr16),
    .prog_data(prog_data16), .start(start16), .busy(busy16), .halted(halted16), .pc(pc16),
    .ovf(ovf16), .regs_flat(regs_flat16)
  );

  typedef struct packed {
    logic [7:0][19:0] prog;
    logic [3:0][7:0]  r;
    logic [5:0]       pc;
    logic             ovf;
    logic [7:0]       cycles;
  } vec_t;

  vec_t vecs [5];
  vec_t sb [$];
  vec_t exp_v;
  logic [127:0] exp16;

  function automatic logic [19:0] ins(input int op, input int rd, input int rs, input int imm);
    return {op[3:0], rd[3:0], rs[3:0], imm[7:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load(input logic [7:0][19:0] p);
    for (int a = 0; a < 8; a++) begin
      prog_we   = 1'b1;
      prog_addr = 6'(a);
      prog_data = p[a];
      tick(1);
    end
    prog_we = 1'b0;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    cyc   = 0;
  endtask

  task automatic wait_halt();
    while (!halted && cyc < 200) tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Program table; unused words are all-ones, i.e. HALT.
    for (int i = 0; i < 5; i++) vecs[i].prog = '1;
    vecs[0].prog[0] = ins(6, 1, 0, 'h05);
    vecs[0].prog[1] = ins(6, 2, 0, 'hFD);
    vecs[0].prog[2] = ins(1, 3, 1, 2);
    vecs[0].r = {8'h02, 8'hFD, 8'h05, 8'h00}; vecs[0].pc = 3; vecs[0].ovf = 0; vecs[0].cycles = 8;

    vecs[1].prog[0] = ins(6, 1, 0, 'h7F);
    vecs[1].prog[1] = ins(5, 1, 1, 1);
    vecs[1].r = {8'h02, 8'hFD, 8'h80, 8'h00}; vecs[1].pc = 2; vecs[1].ovf = 1; vecs[1].cycles = 6;

    vecs[2].prog[0] = ins(6, 2, 0, 'h0C);
    vecs[2].prog[1] = ins(6, 3, 0, 'h0A);
    vecs[2].prog[2] = ins(3, 0, 2, 3);
    vecs[2].prog[3] = ins(4, 1, 2, 3);
    vecs[2].r = {8'h0A, 8'h0C, 8'h0E, 8'h08}; vecs[2].pc = 4; vecs[2].ovf = 0; vecs[2].cycles = 10;

    vecs[3].prog[0] = ins(6, 1, 0, 'h80);
    vecs[3].prog[1] = ins(6, 2, 0, 'h01);
    vecs[3].prog[2] = ins(2, 3, 1, 2);
    vecs[3].prog[3] = ins(9, 0, 1, 'h55);
    vecs[3].r = {8'h7F, 8'h01, 8'h80, 8'h08}; vecs[3].pc = 4; vecs[3].ovf = 1; vecs[3].cycles = 10;

    vecs[4].prog[0] = ins(6, 1, 0, 3);
    vecs[4].prog[1] = ins(5, 1, 1, 'hFF);
    vecs[4].prog[2] = ins(7, 0, 1, 4);
    vecs[4].prog[3] = ins(8, 0, 0, 1);
    vecs[4].r = {8'h7F, 8'h01, 8'h00, 8'h08}; vecs[4].pc = 4; vecs[4].ovf = 0; vecs[4].cycles = 20;

    reset = 1'b1; hold = 1'b0; prog_we = 1'b0; start = 1'b0;
    prog_addr = '0; prog_data = '0;
    prog_we16 = 1'b0; start16 = 1'b0; prog_addr16 = '0; prog_data16 = '0;
    tick(2);
    reset = 1'b0;

    check("reset_busy",   busy,        1'b0);
    check("reset_halted", halted,      1'b0);
    check("reset_pc",     pc,          6'd0);
    check("reset_ovf",    ovf,         1'b0);
    check("reset_regs",   regs_flat,   32'h0);
    check("reset_regs16", regs_flat16, 128'h0);

    for (int i = 0; i < 5; i++) begin
      load(vecs[i].prog);
      sb.push_back(vecs[i]);
      run_start();
      wait_halt();
      exp_v = sb.pop_front();
      check($sformatf("v%0d_halted", i), halted, 1'b1);
      check($sformatf("v%0d_cycles", i), cyc, exp_v.cycles);
      check($sformatf("v%0d_pc", i), pc, exp_v.pc);
      check($sformatf("v%0d_ovf", i), ovf, exp_v.ovf);
      for (int r = 0; r < 4; r++)
        check($sformatf("v%0d_r%0d", i, r), regs_flat[r*8 +: 8], exp_v.r[r]);
    end

    // Start with hold in HALT: start wins, then the core freezes in FETCH.
    hold = 1'b1;
    run_start();
    check("hs_busy", busy, 1'b1);
    check("hs_pc",   pc,   6'd0);
    tick(2);
    check("hs_frozen_busy", busy,            1'b1);
    check("hs_frozen_r1",   regs_flat[15:8], 8'h00);
    hold = 1'b0;
    tick(2);
    check("first_write_r1", regs_flat[15:8], 8'h03);
    check("first_write_pc", pc,              6'd1);
    tick(1);
    hold = 1'b1;
    tick(5);
    check("hold_pc",   pc,              6'd1);
    check("hold_r1",   regs_flat[15:8], 8'h03);
    check("hold_busy", busy,            1'b1);
    hold = 1'b0;
    wait_halt();
    check("hold_cycles", cyc,             27);
    check("hold_r1_end", regs_flat[15:8], 8'h00);
    check("hold_pc_end", pc,              6'd4);

    // Program writes and start pulses while busy must be ignored.
    run_start();
    tick(3);
    prog_we = 1'b1; prog_addr = 6'd0; prog_data = ins(6, 1, 0, 9); start = 1'b1;
    tick(1);
    prog_we = 1'b0; start = 1'b0;
    wait_halt();
    check("busy_start_cycles", cyc, 20);
    run_start();
    wait_halt();
    check("busy_write_cycles", cyc,             20);
    check("busy_write_r1",     regs_flat[15:8], 8'h00);

    // Reset in the middle of a run, then rerun the stored program.
    run_start();
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_busy",   busy,      1'b0);
    check("midrst_halted", halted,    1'b0);
    check("midrst_pc",     pc,        6'd0);
    check("midrst_ovf",    ovf,       1'b0);
    check("midrst_regs",   regs_flat, 32'h0);
    run_start();
    wait_halt();
    check("rerun_cycles", cyc,       20);
    check("rerun_pc",     pc,        6'd4);
    check("rerun_regs",   regs_flat, 32'h0);

    // Wide configuration: sign extension to 16 bits and out-of-range indices.
    for (int a = 0; a < 6; a++) begin
      prog_we16   = 1'b1;
      prog_addr16 = 6'(a);
      case (a)
        0: prog_data16 = ins(6, 1, 0, 'h11);
        1: prog_data16 = ins(6, 7, 0, 'h80);
        2: prog_data16 = ins(1, 7, 7, 7);
        3: prog_data16 = ins(6, 9, 0, 'h55);
        4: prog_data16 = ins(5, 2, 9, 5);
        default: prog_data16 = ins(15, 0, 0, 0);
      endcase
      tick(1);
    end
    prog_we16 = 1'b0;
    start16 = 1'b1;
    tick(1);
    start16 = 1'b0;
    cyc = 0;
    tick(4);
    check("w16_li_r7", regs_flat16[7*16 +: 16], 16'hFF80);
    while (!halted16 && cyc < 200) tick(1);
    exp16 = '0;
    exp16[1*16 +: 16] = 16'h0011;
    exp16[2*16 +: 16] = 16'h0005;
    exp16[7*16 +: 16] = 16'hFF00;
    check("w16_cycles", cyc,  12);
    check("w16_pc",     pc16, 6'd5);
    check("w16_ovf",    ovf16, 1'b0);
    for (int r = 0; r < 8; r++)
      check($sformatf("w16_r%0d", r), regs_flat16[r*16 +: 16], exp16[r*16 +: 16]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
